// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP pixel-bus test source.
//   state_t    : source FSM states
//   DVP_DW     : pixel data width
//   ramp_value : test-pattern value for a given pixel/line (0-based)
package dvp_pkg;

  localparam int DVP_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VSYNC  = 2'd1,
    HBLANK = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  // Ramp pattern: (pix + line + 1) truncated to the bus width, wrapping silently.
  function automatic logic [DVP_DW-1:0] ramp_value(input logic [31:0] pix,
                                                   input logic [31:0] line);
    return DVP_DW'(pix + line + 32'd1);
  endfunction

endpackage

// File: rtl/dvp_source.sv
// Camera-side DVP transmitter producing OV-style frame/line timing and a
// deterministic ramp pattern, for driving a pixel-bus consumer without a sensor.
//
// Ports:
//   pclk        pixel clock, all logic on the rising edge
//   rst         synchronous reset, active-high
//   start       frame request, honoured only in IDLE
//   continuous  sampled at end of frame: 1 starts the next frame immediately
//   vsync       frame sync, high for VSYNC_CYC cycles at frame start
//   href        line valid, high during active pixels
//   dout        pixel data, 0 whenever href is low
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse in the cycle after the last pixel of a frame
//
// Every output is a register updated on the same edge as the state change that
// defines it, so the outputs always line up with the FSM without a lag cycle.
module dvp_source
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = 410,
  parameter int H_BLANK   = 2,
  parameter int V_LINES   = 3,
  parameter int VSYNC_CYC = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              vsync,
  output logic              href,
  output logic [DVP_DW-1:0] dout,
  output logic              busy,
  output logic              frame_done
);

  // Counter widths, at least one bit even when a count is 1.
  localparam int PW = (H_ACTIVE  > 1) ? $clog2(H_ACTIVE)  : 1;
  localparam int LW = (V_LINES   > 1) ? $clog2(V_LINES)   : 1;
  localparam int BW = (H_BLANK   > 1) ? $clog2(H_BLANK)   : 1;
  localparam int VW = (VSYNC_CYC > 1) ? $clog2(VSYNC_CYC) : 1;

  localparam logic [PW-1:0] PIX_LAST   = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST  = LW'(V_LINES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(H_BLANK - 1);
  localparam logic [VW-1:0] VS_LAST    = VW'(VSYNC_CYC - 1);

  state_t        state;
  logic [PW-1:0] pix;
  logic [LW-1:0] line;
  logic [BW-1:0] bcnt;
  logic [VW-1:0] vcnt;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values of pix/line/counters regardless of order.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= IDLE;
      pix        <= '0;
      line       <= '0;
      bcnt       <= '0;
      vcnt       <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      dout       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= VSYNC;
            vsync <= 1'b1;
            busy  <= 1'b1;
            vcnt  <= '0;
            pix   <= '0;
            line  <= '0;
          end
        end

        VSYNC: begin
          if (vcnt == VS_LAST) begin
            state <= HBLANK;
            vsync <= 1'b0;
            bcnt  <= '0;
          end else begin
            vcnt <= vcnt + 1'b1;
          end
        end

        HBLANK: begin
          if (bcnt == BLANK_LAST) begin
            state <= ACTIVE;
            href  <= 1'b1;
            pix   <= '0;
            dout  <= ramp_value(32'd0, 32'(line));
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end

        ACTIVE: begin
          if (pix == PIX_LAST) begin
            href <= 1'b0;
            dout <= '0;
            if (line == LINE_LAST) begin
              frame_done <= 1'b1;
              if (continuous) begin
                // Back-to-back frame: vsync rises in the frame_done cycle.
                state <= VSYNC;
                vsync <= 1'b1;
                vcnt  <= '0;
                pix   <= '0;
                line  <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              state <= HBLANK;
              line  <= line + 1'b1;
              bcnt  <= '0;
            end
          end else begin
            pix  <= pix + 1'b1;
            dout <= ramp_value(32'(pix) + 32'd1, 32'(line));
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_source.sv
// Self-checking bench for dvp_source: one instance with default timing and one
// small instance (H_ACTIVE=4, H_BLANK=1, V_LINES=1, VSYNC_CYC=2).
module tb_dvp_source;

  localparam int HA    = 410;
  localparam int HB    = 2;
  localparam int VL    = 3;
  localparam int VS    = 1;
  localparam int FRAME = VS + VL * (HB + HA);  // 1237
  localparam int CAP   = 2600;

  typedef struct packed {
    logic       vsync;
    logic       href;
    logic [7:0] dout;
    logic       busy;
    logic       fd;
  } sample_t;

  typedef struct {
    int      cyc;
    sample_t exp;
  } vec_t;

  logic       pclk = 1'b0;
  logic       rst_a, start_a, cont_a;
  logic       rst_b, start_b, cont_b;
  logic       vsync_a, href_a, busy_a, fd_a;
  logic       vsync_b, href_b, busy_b, fd_b;
  logic [7:0] dout_a, dout_b;

  int checks = 0;
  int errors = 0;

  sample_t cap_a [CAP];
  sample_t cap_b [CAP];
  vec_t    va [16];
  vec_t    vb [9];

  always #5 pclk = ~pclk;

  dvp_source dut_a (
    .pclk       (pclk),
    .rst        (rst_a),
    .start      (start_a),
    .continuous (cont_a),
    .vsync      (vsync_a),
    .href       (href_a),
    .dout       (dout_a),
    .busy       (busy_a),
    .frame_done (fd_a)
  );

  dvp_source #(
    .H_ACTIVE  (4),
    .H_BLANK   (1),
    .V_LINES   (1),
    .VSYNC_CYC (2)
  ) dut_b (
    .pclk       (pclk),
    .rst        (rst_b),
    .start      (start_b),
    .continuous (cont_b),
    .vsync      (vsync_b),
    .href       (href_b),
    .dout       (dout_b),
    .busy       (busy_b),
    .frame_done (fd_b)
  );

  function automatic sample_t mk(input logic v, input logic h, input int d,
                                 input logic b, input logic f);
    sample_t s;
    s.vsync = v;
    s.href  = h;
    s.dout  = 8'(d);
    s.busy  = b;
    s.fd    = f;
    return s;
  endfunction

  // Independent frame model for the default instance, t = cycles since vsync rose.
  function automatic sample_t model_a(input int t);
    sample_t s;
    int u, l, r;
    s = '0;
    s.busy = 1'b1;
    if (t < VS) begin
      s.vsync = 1'b1;
    end else begin
      u = t - VS;
      l = u / (HB + HA);
      r = u % (HB + HA);
      if (r >= HB) begin
        s.href = 1'b1;
        s.dout = 8'((r - HB) + l + 1);
      end
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  // Sample point: 1 time unit after each rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Records n cycles of both instances; optionally pulses start_a or drops cont_a
  // during the cycle with the given index.
  task automatic capture(input int n, input int start_at, input int drop_at);
    for (int i = 0; i < n; i++) begin
      cap_a[i] = '{vsync: vsync_a, href: href_a, dout: dout_a, busy: busy_a, fd: fd_a};
      cap_b[i] = '{vsync: vsync_b, href: href_b, dout: dout_b, busy: busy_b, fd: fd_b};
      start_a = (i == start_at);
      if (i == drop_at) cont_a = 1'b0;
      step();
    end
    start_a = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // Compares one whole captured frame against the model; fd_first marks a frame
  // that starts in the frame_done cycle of the previous one.
  task automatic check_frame(input string name, input int base, input bit fd_first);
    int bad = 0;
    int first_bad = -1;
    sample_t e;
    for (int t = 0; t < FRAME; t++) begin
      e = model_a(t);
      if (t == 0) e.fd = fd_first;
      if (cap_a[base + t] !== e) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
    end
    check($sformatf("%s mismatching cycles (first at t=%0d)", name, first_bad), bad, 0);
  endtask

  function automatic int first_fd(input int n);
    for (int i = 0; i < n; i++) if (cap_a[i].fd) return i;
    return -1;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, rises, ovl, hcyc;

    // Default-instance vectors, cycle 0 = first vsync cycle.
    va[0]  = '{0,    mk(1, 0, 0,   1, 0)};
    va[1]  = '{1,    mk(0, 0, 0,   1, 0)};
    va[2]  = '{2,    mk(0, 0, 0,   1, 0)};
    va[3]  = '{3,    mk(0, 1, 1,   1, 0)};  // line 0 pix 0
    va[4]  = '{4,    mk(0, 1, 2,   1, 0)};
    va[5]  = '{257,  mk(0, 1, 255, 1, 0)};  // line 0 pix 254
    va[6]  = '{258,  mk(0, 1, 0,   1, 0)};  // line 0 pix 255 wraps
    va[7]  = '{412,  mk(0, 1, 154, 1, 0)};  // line 0 last pixel
    va[8]  = '{413,  mk(0, 0, 0,   1, 0)};  // line 1 blank
    va[9]  = '{415,  mk(0, 1, 2,   1, 0)};  // line 1 pix 0
    va[10] = '{826,  mk(0, 0, 0,   1, 0)};  // line 2 blank
    va[11] = '{827,  mk(0, 1, 3,   1, 0)};  // line 2 pix 0
    va[12] = '{1080, mk(0, 1, 0,   1, 0)};  // line 2 pix 253 wraps
    va[13] = '{1236, mk(0, 1, 156, 1, 0)};  // last pixel of frame
    va[14] = '{1237, mk(0, 0, 0,   0, 1)};  // frame_done, busy already low
    va[15] = '{1238, mk(0, 0, 0,   0, 0)};

    // Small-instance vectors.
    vb[0] = '{0, mk(1, 0, 0, 1, 0)};
    vb[1] = '{1, mk(1, 0, 0, 1, 0)};
    vb[2] = '{2, mk(0, 0, 0, 1, 0)};
    vb[3] = '{3, mk(0, 1, 1, 1, 0)};
    vb[4] = '{4, mk(0, 1, 2, 1, 0)};
    vb[5] = '{5, mk(0, 1, 3, 1, 0)};
    vb[6] = '{6, mk(0, 1, 4, 1, 0)};
    vb[7] = '{7, mk(0, 0, 0, 0, 1)};
    vb[8] = '{8, mk(0, 0, 0, 0, 0)};

    // NOTE: stimulus is driven with blocking assignments away from the edge;
    // the DUT samples it on the following rising edge.
    rst_a = 1'b1; start_a = 1'b0; cont_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; cont_b = 1'b0;
    repeat (3) step();
    check("reset state A", {vsync_a, href_a, dout_a, busy_a, fd_a}, '0);
    check("reset state B", {vsync_b, href_b, dout_b, busy_b, fd_b}, '0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();

    // Reset mid-ACTIVE at line 1, pix 100.
    pulse_start_a();
    capture(515, -1, -1);
    check("pre-reset href at line1 pix100", href_a, 1);
    check("pre-reset dout at line1 pix100", dout_a, 102);
    rst_a = 1'b1;
    step();
    check("mid-line reset outputs", {vsync_a, href_a, dout_a, busy_a, fd_a}, '0);
    rst_a = 1'b0;
    step();
    check("idle after reset", {vsync_a, href_a, dout_a, busy_a, fd_a}, '0);

    // Clean single frame after reset: start latency and table vectors.
    pulse_start_a();
    capture(1240, -1, -1);
    for (int i = 0; i < 16; i++)
      check($sformatf("frame vector cyc %0d", va[i].cyc), cap_a[va[i].cyc], va[i].exp);
    check_frame("single frame", 0, 1'b0);
    rises = 0; ovl = 0; hcyc = 0;
    for (int i = 0; i < 1240; i++) begin
      if (cap_a[i].href && (i == 0 || !cap_a[i-1].href)) rises++;
      if (cap_a[i].href && cap_a[i].vsync) ovl++;
      if (cap_a[i].href) hcyc++;
    end
    check("href pulses per frame", rises, 3);
    check("href high cycles per frame", hcyc, 3 * HA);
    check("vsync/href overlap cycles", ovl, 0);
    check("frame_done offset", first_fd(1240), FRAME);

    // start during line 1 HBLANK is ignored.
    pulse_start_a();
    capture(1240, 413, -1);
    check_frame("frame with ignored start", 0, 1'b0);
    check("ignored start frame_done offset", first_fd(1240), FRAME);
    cnt = 0;
    for (int i = 0; i < 1240; i++) if (cap_a[i].vsync) cnt++;
    check("ignored start vsync cycles", cnt, 1);
    check("ignored start ends idle", busy_a, 0);

    // Continuous mode, continuous dropped during the second frame.
    cont_a = 1'b1;
    pulse_start_a();
    capture(2480, -1, 1500);
    check_frame("continuous frame 1", 0, 1'b0);
    check_frame("continuous frame 2", FRAME, 1'b1);
    check("frame_done 1 with vsync", {cap_a[FRAME].fd, cap_a[FRAME].vsync, cap_a[FRAME].busy}, 3'b111);
    check("frame_done 2 then idle", {cap_a[2*FRAME].fd, cap_a[2*FRAME].vsync, cap_a[2*FRAME].busy}, 3'b100);
    cnt = 0;
    for (int i = 0; i < 2480; i++) if (cap_a[i].fd) cnt++;
    check("continuous frame_done pulses", cnt, 2);
    check("idle after continuous dropped", {cap_a[2479].busy, cap_a[2479].vsync}, 2'b00);

    // Small parameter set.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    capture(9, -1, -1);
    for (int i = 0; i < 9; i++)
      check($sformatf("small cfg cyc %0d", vb[i].cyc), cap_b[vb[i].cyc], vb[i].exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
